// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// the latched request record and the alignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } lsu_size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_READ,
    ST_WRITE,
    ST_ERR
  } lsu_state_t;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int CNT_W     = 16;

  typedef struct packed {
    logic        write;
    lsu_size_t   size;
    logic        uns;
    logic [1:0]  offset;
    logic [31:0] wdata;
  } lsu_req_t;

  // Reserved size is flagged separately; this only covers natural alignment.
  function automatic logic is_misaligned(lsu_size_t size, logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian byte-lane steering: extracts and extends a load lane, and merges
// store data into an old word for the read-modify-write path.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] ext_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  lsu_size_t   size,
  input  logic        uns,
  output logic [31:0] ext_data,
  output logic [31:0] merged
);

  logic [NUM_LANES-1:0][LANE_W-1:0] old_lanes, wd_lanes, new_lanes;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign old_lanes = old_word;
  assign wd_lanes  = wdata;
  assign merged    = new_lanes;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = ext_word[31:24];
      2'd1:    byte_sel = ext_word[23:16];
      2'd2:    byte_sel = ext_word[15:8];
      default: byte_sel = ext_word[7:0];
    endcase
    half_sel = offset[1] ? ext_word[15:0] : ext_word[31:16];
    case (size)
      SZ_BYTE: ext_data = {{24{~uns & byte_sel[7]}}, byte_sel};
      SZ_HALF: ext_data = {{16{~uns & half_sel[15]}}, half_sel};
      SZ_WORD: ext_data = ext_word;
      default: ext_data = '0;
    endcase
  end

  // Packed lane i holds big-endian byte offset NUM_LANES-1-i.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] OFF = 2'(NUM_LANES - 1 - i);
    logic             sel;
    logic [LANE_W-1:0] wr;

    always_comb begin
      sel = 1'b0;
      wr  = old_lanes[i];
      case (size)
        SZ_BYTE: begin
          sel = (offset == OFF);
          wr  = wdata[7:0];
        end
        SZ_HALF: begin
          sel = (offset[1] == OFF[1]);
          wr  = OFF[0] ? wdata[7:0] : wdata[15:8];
        end
        SZ_WORD: begin
          sel = 1'b1;
          wr  = wd_lanes[i];
        end
        default: ;
      endcase
    end

    assign new_lanes[i] = sel ? wr : old_lanes[i];
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the memory stage and a word-wide data memory with
// combinational reads. Define LSU_PERF_CNT_EN to add saturating access counters.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count,
  output logic [CNT_W-1:0]  err_count
`endif
);

  lsu_state_t        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       old_q, old_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  lsu_size_t         req_size_t;
  logic [ADDR_W-1:0] req_idx;
  logic              req_err;
  logic [31:0]       ext_data, merged;

  assign req_size_t = lsu_size_t'(req_size);
  assign req_idx    = req_addr >> 2;
  assign req_err    = (req_size_t == SZ_RSVD)
                    | is_misaligned(req_size_t, req_addr[1:0])
                    | (req_idx >= ADDR_W'(DEPTH));

  lsu_lane_align u_align (
    .ext_word (mem_read_data),
    .old_word (old_q),
    .wdata    (req_q.wdata),
    .offset   (req_q.offset),
    .size     (req_q.size),
    .uns      (req_q.uns),
    .ext_data (ext_data),
    .merged   (merged)
  );

  // Memory strobes come from state only so an async reset drops them at once.
  assign req_ready      = (state_q == ST_IDLE);
  assign mem_write      = (state_q == ST_WRITE);
  assign mem_address    = idx_q;
  assign mem_write_data = mem_write ? merged : '0;
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = resp_rdata_q;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    idx_d        = idx_q;
    old_d        = old_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d = '{write: req_write, size: req_size_t, uns: req_unsigned,
                    offset: req_addr[1:0], wdata: req_wdata};
          idx_d = req_idx;
          if (req_err) begin
            // Errors respond while still in ERR, one cycle after accept.
            state_d      = ST_ERR;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_write) begin
            state_d = ST_LOAD;
          end else if (req_size_t == SZ_WORD) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RMW_READ;
          end
        end
      end
      ST_LOAD: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = ext_data;
        state_d      = ST_IDLE;
      end
      ST_RMW_READ: begin
        old_d   = mem_read_data;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        resp_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      idx_q        <= '0;
      old_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      idx_q        <= idx_d;
      old_q        <= old_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

`ifdef LSU_PERF_CNT_EN
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] store_cnt_q, store_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // req_q still describes the responding access during its resp cycle.
  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (resp_valid_q) begin
      if (resp_err_q) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      end else if (req_q.write) begin
        if (store_cnt_q != '1) store_cnt_d = store_cnt_q + 1'b1;
      end else begin
        if (load_cnt_q != '1) load_cnt_d = load_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign load_count  = load_cnt_q;
  assign store_count = store_cnt_q;
  assign err_count   = err_cnt_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-wide data memory model
// (combinational read, synchronous write).
module tb_load_store_unit;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data, mem_read_data;
`ifdef LSU_PERF_CNT_EN
  logic [15:0]       load_count, store_count, err_count;
`endif

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [31:0] mem [0:DEPTH-1];

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
`ifdef LSU_PERF_CNT_EN
    , .load_count(load_count), .store_count(store_count), .err_count(err_count)
`endif
  );

  assign mem_read_data = (mem_address < ADDR_W'(DEPTH)) ? mem[mem_address[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write) begin
      if (mem_address < ADDR_W'(DEPTH)) mem[mem_address[9:0]] <= mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_write} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctl got %b want 1000", {req_ready, resp_valid, resp_err, mem_write});
    end
    checks++;
    if ({resp_rdata, mem_address, mem_write_data} !== 96'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h want 0", resp_rdata, mem_address, mem_write_data);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_word_store;
    int w0;
    w0 = wr_cnt;
    drive(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL wst_ready got %b want 1", req_ready); end
    step();
    req_valid = 1'b0;
    checks++;
    if ({mem_write, resp_valid} !== 2'b10) begin
      errors++; $display("FAIL wst_t1_ctl got %b want 10", {mem_write, resp_valid});
    end
    checks++;
    if (mem_address !== 32'd2 || mem_write_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wst_t1_bus got %h/%h want 2/deadbeef", mem_address, mem_write_data);
    end
    step();
    checks++;
    if ({mem_write, resp_valid, resp_err} !== 3'b010 || wr_cnt - w0 != 1) begin
      errors++; $display("FAIL wst_t2 got %b writes %0d want 010 writes 1", {mem_write, resp_valid, resp_err}, wr_cnt - w0);
    end
  endtask

  task automatic test_loads;
    logic [1:0]  sz  [6];
    logic        un  [6];
    logic [31:0] ad  [6];
    logic [31:0] ex  [6];
    sz = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0};
    un = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    ad = '{32'h09, 32'h09, 32'h0A, 32'h08, 32'h08, 32'h0B};
    ex = '{32'hFFFFFFAD, 32'h000000AD, 32'hFFFFBEEF, 32'hDEADBEEF, 32'h0000DEAD, 32'hFFFFFFEF};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, sz[i], un[i], ad[i], 32'h0);
      step();
      req_valid = 1'b0;
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL ld%0d_t1 resp_valid got %b want 0", i, resp_valid); end
      step();
      checks++;
      if ({resp_valid, resp_err} !== 2'b10 || resp_rdata !== ex[i]) begin
        errors++; $display("FAIL ld%0d_t2 got v%b e%b %h want v1 e0 %h", i, resp_valid, resp_err, resp_rdata, ex[i]);
      end
    end
  endtask

  task automatic test_subword_store;
    drive(1'b1, 2'd0, 1'b0, 32'h0B, 32'h00000055);
    step();
    req_valid = 1'b0;
    checks++;
    if ({mem_write, resp_valid} !== 2'b00) begin
      errors++; $display("FAIL bst_t1 got %b want 00", {mem_write, resp_valid});
    end
    step();
    checks++;
    if (mem_write !== 1'b1 || mem_write_data !== 32'hDEADBE55 || mem_address !== 32'd2 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL bst_t2 got w%b %h @%h v%b want w1 deadbe55 @2 v0", mem_write, mem_write_data, mem_address, resp_valid);
    end
    step();
    checks++;
    if ({mem_write, resp_valid, resp_err} !== 3'b010) begin
      errors++; $display("FAIL bst_t3 got %b want 010", {mem_write, resp_valid, resp_err});
    end
    drive(1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
    step(); req_valid = 1'b0; step();
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBE55) begin
      errors++; $display("FAIL bst_readback got v%b %h want v1 deadbe55", resp_valid, resp_rdata);
    end
    // Halfword at offset 0 of a zeroed word lands in the upper lanes.
    drive(1'b1, 2'd1, 1'b0, 32'h0C, 32'hABCD1234);
    step(); req_valid = 1'b0; step();
    checks++;
    if (mem_write !== 1'b1 || mem_write_data !== 32'h12340000) begin
      errors++; $display("FAIL hst_merge got w%b %h want w1 12340000", mem_write, mem_write_data);
    end
    step();
  endtask

  task automatic test_errors;
    logic        wr [5];
    logic [1:0]  sz [5];
    logic [31:0] ad [5];
    int          w0;
    wr = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    sz = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd2};
    ad = '{32'h06, 32'h03, 32'h1000, 32'h00, 32'h3FFC};
    for (int i = 0; i < 5; i++) begin
      w0 = wr_cnt;
      drive(wr[i], sz[i], 1'b0, ad[i], 32'hCAFEF00D);
      step();
      req_valid = 1'b0;
      checks++;
      if ({resp_valid, resp_err, req_ready, mem_write} !== 4'b1100 || resp_rdata !== 32'h0) begin
        errors++; $display("FAIL err%0d_t1 got %b %h want 1100 0", i, {resp_valid, resp_err, req_ready, mem_write}, resp_rdata);
      end
      step();
      checks++;
      if ({resp_valid, req_ready} !== 2'b01 || wr_cnt != w0) begin
        errors++; $display("FAIL err%0d_t2 got %b writes %0d want 01 writes 0", i, {resp_valid, req_ready}, wr_cnt - w0);
      end
    end
  endtask

  task automatic test_reset_mid_rmw;
    int w0;
    w0 = wr_cnt;
    drive(1'b1, 2'd0, 1'b0, 32'h0B, 32'h000000AA);
    step();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_write, resp_valid, req_ready} !== 3'b001) begin
      errors++; $display("FAIL rst_async got %b want 001", {mem_write, resp_valid, req_ready});
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({mem_write, resp_valid, req_ready} !== 3'b001 || wr_cnt != w0) begin
      errors++; $display("FAIL rst_after got %b writes %0d want 001 writes 0", {mem_write, resp_valid, req_ready}, wr_cnt - w0);
    end
    drive(1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
    step(); req_valid = 1'b0; step();
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBE55) begin
      errors++; $display("FAIL rst_readback got v%b %h want v1 deadbe55", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_back_to_back;
    // Fresh reset so the counters start from zero; memory contents persist.
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    // 0xFFC is the last in-range word (index DEPTH-1).
    drive(1'b1, 2'd2, 1'b0, 32'hFFC, 32'hFFFFFFFF);
    step();
    drive(1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0);
    checks++;
    if (req_ready !== 1'b0 || mem_write !== 1'b1 || mem_address !== 32'h3FF) begin
      errors++; $display("FAIL b2b_t1 got r%b w%b @%h want r0 w1 @3ff", req_ready, mem_write, mem_address);
    end
    step();
    checks++;
    if ({resp_valid, resp_err, req_ready} !== 3'b101) begin
      errors++; $display("FAIL b2b_t2 got %b want 101", {resp_valid, resp_err, req_ready});
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_t3 got v%b r%b want v0 r0", resp_valid, req_ready);
    end
    step();
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL b2b_load got v%b %h want v1 ffffffff", resp_valid, resp_rdata);
    end
    step();
`ifdef LSU_PERF_CNT_EN
    checks++;
    if (store_count !== 16'd1 || load_count !== 16'd1 || err_count !== 16'd0) begin
      errors++; $display("FAIL perf_cnt got s%0d l%0d e%0d want s1 l1 e0", store_count, load_count, err_count);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    test_reset();
    test_word_store();
    test_loads();
    test_subword_store();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
